// File: rtl/seq_multiplier_if.sv
// -----------------------------------------------------------------------------
// seq_multiplier_if
// Bundles the operand, control and result signals of seq_multiplier.
//
// Handshake (Run/Ready level protocol):
//   The master raises Run with the operands and Signed stable on the same edge.
//   The slave samples them once, on the first posedge where Run=1 in IDLE, and
//   raises Busy. After WIDTH iterations it raises Ready, and Product is valid.
//   Ready and Product stay stable for as long as Run stays high. Dropping Run
//   while Ready is high releases the result and returns the slave to IDLE.
//   Dropping Run while Busy is high aborts the operation. Product keeps its
//   previous value and Ready is not raised. A new operation needs Run low for
//   at least one cycle after Ready.
//
// Signals:
//   Run           master -> slave   start/hold request (level)
//   Signed        master -> slave   1 = two's complement operands
//   Multiplicand  master -> slave   operand A, WIDTH bits
//   Multiplier    master -> slave   operand B, WIDTH bits
//   Product       slave  -> master  2*WIDTH-bit result register
//   Busy          slave  -> master  iteration in progress
//   Ready         slave  -> master  Product valid
//   state         slave  -> master  FSM state for debug/observation
//                                   (00 IDLE, 01 CALC, 10 DONE)
// -----------------------------------------------------------------------------
interface seq_multiplier_if #(
  parameter int WIDTH = 32
);
  logic                 Run;
  logic                 Signed;
  logic [WIDTH-1:0]     Multiplicand;
  logic [WIDTH-1:0]     Multiplier;
  logic [2*WIDTH-1:0]   Product;
  logic                 Busy;
  logic                 Ready;
  logic [1:0]           state;

  modport master (
    output Run, Signed, Multiplicand, Multiplier,
    input  Product, Busy, Ready, state
  );

  modport slave (
    input  Run, Signed, Multiplicand, Multiplier,
    output Product, Busy, Ready, state
  );
endinterface

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
// Iterative shift-add multiplier. It retires one multiplier bit per clock and
// supports signed (two's complement) and unsigned operands. Signed operands are
// handled as sign-and-magnitude. The magnitudes are multiplied unsigned, and the
// 2*WIDTH-bit result is negated on the final edge when the operand signs differ.
//
// Ports:
//   clk    clock; all state updates on posedge
//   Reset  synchronous reset, active low; has priority over everything
//   bus    seq_multiplier_if.slave (Run, Signed, Multiplicand, Multiplier in;
//          Product, Busy, Ready, state out)
//
// Timing: Run is sampled high in IDLE at edge E0, and Busy is high after E0.
// Ready and Product are valid after edge E0+WIDTH. The latency does not depend
// on the operand data.
// -----------------------------------------------------------------------------
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            Reset,
  seq_multiplier_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PW    = 2 * WIDTH;

  // The encoding puts Busy on bit 0 and Ready on bit 1. Both outputs are then
  // plain flop outputs with no decode logic behind them.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [CNT_W-1:0] count_q;
  logic             neg_q;
  logic [WIDTH-1:0] mag_a_q;
  // Working register. In the full formulation it has a top bit acc[2W], and
  // that bit is always written as zero. It is therefore not stored; the
  // register holds only acc[2W-1:0].
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    product_q;

  logic             neg_in;
  logic [WIDTH-1:0] mag_a_in;
  logic [WIDTH-1:0] mag_b_in;
  logic [WIDTH:0]   sum;
  logic [PW-1:0]    acc_next;
  logic [PW-1:0]    product_next;
  logic             last_iter;

  // ---------------------------------------------------------------------------
  // Operand conditioning at load. The magnitude is an unsigned WIDTH-bit value,
  // so the most negative operand maps cleanly to 2^(WIDTH-1).
  // ---------------------------------------------------------------------------
  always_comb begin
    neg_in   = bus.Signed & (bus.Multiplicand[WIDTH-1] ^ bus.Multiplier[WIDTH-1]);
    mag_a_in = (bus.Signed && bus.Multiplicand[WIDTH-1])
               ? (~bus.Multiplicand + WIDTH'(1)) : bus.Multiplicand;
    mag_b_in = (bus.Signed && bus.Multiplier[WIDTH-1])
               ? (~bus.Multiplier + WIDTH'(1)) : bus.Multiplier;
  end

  // ---------------------------------------------------------------------------
  // One shift-add step. The carry out of the upper-half add is kept in sum[W],
  // and the shift moves it back into the top of the working register.
  // ---------------------------------------------------------------------------
  always_comb begin
    sum          = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);
    acc_next     = {sum, acc_q[WIDTH-1:1]};
    product_next = neg_q ? (~acc_next + PW'(1)) : acc_next;
    last_iter    = (count_q == CNT_W'(1));
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.Run) state_d = CALC;
      end
      CALC: begin
        if (!bus.Run)      state_d = IDLE;  // abort
        else if (last_iter) state_d = DONE;
      end
      DONE: begin
        // Ready holds until the master releases Run. No direct restart from DONE.
        if (!bus.Run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (the flop bits of the state register feed the outputs directly)
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.Busy    = state_q[0];
    bus.Ready   = state_q[1];
    bus.state   = state_q;
    bus.Product = product_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!Reset) begin
      count_q   <= '0;
      neg_q     <= 1'b0;
      mag_a_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.Run) begin
            neg_q   <= neg_in;
            mag_a_q <= mag_a_in;
            acc_q   <= {{WIDTH{1'b0}}, mag_b_in};
            count_q <= CNT_W'(WIDTH);
          end
        end
        CALC: begin
          // With Run low this is an abort. Nothing is written, so Product keeps
          // its previous result.
          if (bus.Run) begin
            acc_q   <= acc_next;
            count_q <= count_q - CNT_W'(1);
            if (last_iter) product_q <= product_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier
// Bench for seq_multiplier. It has two instances: WIDTH=8 for the directed
// cases and WIDTH=32 for the wide and random cases. Driver tasks issue
// operations and push the expected product into a per-instance queue. A
// separate monitor pops and compares the queue on every rising edge of Ready.
// -----------------------------------------------------------------------------
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic Reset;

  always #5 clk = ~clk;

  seq_multiplier_if #(.WIDTH(8))  b8 ();
  seq_multiplier_if #(.WIDTH(32)) b32 ();

  seq_multiplier #(.WIDTH(8)) u8 (
    .clk   (clk),
    .Reset (Reset),
    .bus   (b8)
  );

  seq_multiplier #(.WIDTH(32)) u32 (
    .clk   (clk),
    .Reset (Reset),
    .bus   (b32)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [15:0] exp8_q[$];
  logic [63:0] exp32_q[$];

  logic [63:0] last8;
  logic [63:0] last32;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic is_ready(input int sel);
    return (sel == 0) ? b8.Ready : b32.Ready;
  endfunction

  function automatic logic is_busy(input int sel);
    return (sel == 0) ? b8.Busy : b32.Busy;
  endfunction

  function automatic logic [63:0] prod(input int sel);
    return (sel == 0) ? {48'b0, b8.Product} : b32.Product;
  endfunction

  function automatic logic [63:0] st(input int sel);
    return (sel == 0) ? {62'b0, b8.state} : {62'b0, b32.state};
  endfunction

  // Reference model for the wide instance, built from plain integer arithmetic.
  function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] sp;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      sp = sa * sb;
      return sp;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic issue(input int sel, input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    if (sel == 0) begin
      b8.Multiplicand = a[7:0];
      b8.Multiplier   = b[7:0];
      b8.Signed       = s;
      b8.Run          = 1'b1;
    end else begin
      b32.Multiplicand = a;
      b32.Multiplier   = b;
      b32.Signed       = s;
      b32.Run          = 1'b1;
    end
  endtask

  task automatic set_run(input int sel, input logic v);
    if (sel == 0) b8.Run = v;
    else          b32.Run = v;
  endtask

  // Counts edges from the load edge until Ready is seen. It checks the total
  // latency and the number of Busy cycles. With scramble set, it changes the
  // operands after the load to show that they are no longer used.
  task automatic wait_ready(input int sel, input int exp_edges, input bit scramble, input string name);
    int edges;
    int busy_n;
    edges  = 0;
    busy_n = 0;
    for (int i = 0; i < exp_edges + 20; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (is_busy(sel)) busy_n++;
      if (scramble && edges == 1) begin
        if (sel == 0) begin
          b8.Multiplicand = 8'($urandom_range(0, 255));
          b8.Multiplier   = 8'($urandom_range(0, 255));
          b8.Signed       = ~b8.Signed;
        end else begin
          b32.Multiplicand = $urandom;
          b32.Multiplier   = $urandom;
          b32.Signed       = ~b32.Signed;
        end
      end
      if (is_ready(sel)) break;
    end
    check({name, " latency"}, 64'(edges), 64'(exp_edges));
    check({name, " busy cycles"}, 64'(busy_n), 64'(exp_edges - 1));
  endtask

  // Runs a full operation with Run held. It checks the latency and the Product
  // hold while Run stays high, then releases Run and checks the return to IDLE.
  task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [63:0] exp, input string name,
                        input bit full_checks);
    if (sel == 0) exp8_q.push_back(exp[15:0]);
    else          exp32_q.push_back(exp);
    issue(sel, a, b, s);
    wait_ready(sel, (sel == 0) ? 9 : 33, 1'b1, name);
    if (full_checks) begin
      @(posedge clk);
      #1;
      check({name, " ready held"}, 64'(is_ready(sel)), 64'd1);
      check({name, " product held"}, prod(sel), exp);
    end
    @(negedge clk);
    set_run(sel, 1'b0);
    @(posedge clk);
    #1;
    if (full_checks) begin
      check({name, " ready dropped"}, 64'(is_ready(sel)), 64'd0);
      check({name, " product kept"}, prod(sel), exp);
    end
    if (sel == 0) last8 = exp;
    else          last32 = exp;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  logic r8_d  = 1'b0;
  logic r32_d = 1'b0;

  always @(negedge clk) begin
    if (b8.Ready === 1'b1 && !r8_d) begin
      n_vec++;
      if (exp8_q.size() == 0) begin
        n_bad++;
        $display("FAIL mon8 unexpected result: got %h expected none", b8.Product);
      end else begin
        logic [15:0] e8;
        e8 = exp8_q.pop_front();
        if (b8.Product !== e8) begin
          n_bad++;
          $display("FAIL mon8 product: got %h expected %h", b8.Product, e8);
        end
      end
    end
    if (b32.Ready === 1'b1 && !r32_d) begin
      n_vec++;
      if (exp32_q.size() == 0) begin
        n_bad++;
        $display("FAIL mon32 unexpected result: got %h expected none", b32.Product);
      end else begin
        logic [63:0] e32;
        e32 = exp32_q.pop_front();
        if (b32.Product !== e32) begin
          n_bad++;
          $display("FAIL mon32 product: got %h expected %h", b32.Product, e32);
        end
      end
    end
    r8_d  <= (b8.Ready === 1'b1);
    r32_d <= (b32.Ready === 1'b1);
  end

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    Reset = 1'b0;
    b8.Run = 1'b0;  b8.Signed = 1'b0;  b8.Multiplicand = '0;  b8.Multiplier = '0;
    b32.Run = 1'b0; b32.Signed = 1'b0; b32.Multiplicand = '0; b32.Multiplier = '0;
    last8 = '0;
    last32 = '0;

    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check("reset product", prod(s), 64'd0);
      check("reset busy",    64'(is_busy(s)), 64'd0);
      check("reset ready",   64'(is_ready(s)), 64'd0);
      check("reset state",   st(s), 64'd0);
    end
    @(negedge clk);
    Reset = 1'b1;

    // Directed 8-bit vectors with hand-computed products
    run_op(0, 32'd13,   32'd11,   1'b0, 64'h008F, "u 13*11",     1'b1);
    run_op(0, 32'hFF,   32'hFF,   1'b0, 64'hFE01, "u 255*255",   1'b1);
    run_op(0, 32'hFF,   32'hFF,   1'b1, 64'h0001, "s -1*-1",     1'b1);
    run_op(0, 32'hFD,   32'h05,   1'b1, 64'hFFF1, "s -3*5",      1'b1);
    run_op(0, 32'h80,   32'h80,   1'b1, 64'h4000, "s -128*-128", 1'b1);
    run_op(0, 32'h80,   32'h7F,   1'b1, 64'hC080, "s -128*127",  1'b1);
    run_op(0, 32'h7F,   32'h7F,   1'b1, 64'h3F01, "s 127*127",   1'b1);
    run_op(0, 32'h80,   32'h80,   1'b0, 64'h4000, "u 128*128",   1'b1);
    run_op(0, 32'h00,   32'hC5,   1'b1, 64'h0000, "s 0*x",       1'b1);
    run_op(0, 32'h07,   32'hFE,   1'b1, 64'hFFF2, "s 7*-2",      1'b1);

    // Abort after four CALC cycles: the load edge plus four iteration edges
    issue(0, 32'd7, 32'd9, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    set_run(0, 1'b0);
    @(posedge clk);
    #1;
    check("abort busy",    64'(is_busy(0)), 64'd0);
    check("abort ready",   64'(is_ready(0)), 64'd0);
    check("abort state",   st(0), 64'd0);
    check("abort product", prod(0), last8);
    run_op(0, 32'd2, 32'd3, 1'b0, 64'd6, "restart 2*3", 1'b1);

    // Reset in mid-CALC with Run held through the release
    issue(0, 32'd13, 32'd11, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    Reset = 1'b0;
    @(posedge clk);
    #1;
    check("rst calc product", prod(0), 64'd0);
    check("rst calc busy",    64'(is_busy(0)), 64'd0);
    check("rst calc ready",   64'(is_ready(0)), 64'd0);
    check("rst calc state",   st(0), 64'd0);
    exp8_q.push_back(16'h008F);
    @(negedge clk);
    Reset = 1'b1;
    wait_ready(0, 9, 1'b0, "post-reset run");
    @(negedge clk);
    set_run(0, 1'b0);
    @(posedge clk);

    // Reset while in DONE
    exp8_q.push_back(16'hFFF1);
    issue(0, 32'hFD, 32'h05, 1'b1);
    wait_ready(0, 9, 1'b0, "pre-reset done");
    @(negedge clk);
    Reset = 1'b0;
    set_run(0, 1'b0);
    @(posedge clk);
    #1;
    check("rst done product", prod(0), 64'd0);
    check("rst done busy",    64'(is_busy(0)), 64'd0);
    check("rst done ready",   64'(is_ready(0)), 64'd0);
    check("rst done state",   st(0), 64'd0);
    @(negedge clk);
    Reset = 1'b1;

    // Wide instance
    run_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, "w32 u max*max", 1'b1);
    run_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001, "w32 s -1*-1",   1'b1);
    run_op(1, 32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, "w32 s min*min", 1'b1);
    for (int i = 0; i < 500; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      if (i % 7 == 0) a = 32'h80000000;
      if (i % 11 == 0) b = 32'd0;
      run_op(1, a, b, s, ref32(a, b, s), "w32 rand", 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue8 drained",  64'(exp8_q.size()), 64'd0);
    check("queue32 drained", 64'(exp32_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
